// File: rtl/ras_bp_if.sv
// Bundles the fetch, RAS, decode and CSR-event signals of the RAS branch-predictor front end.
// The predictor itself uses the master modport; the surrounding pipeline uses slave.
interface ras_bp_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  fetch_bp_valid;
    logic [ADDR_WIDTH-1:0] fetch_bp_pc;
    logic [31:0]           fetch_bp_inst;
    logic                  bp_fetch_ready;

    logic [ADDR_WIDTH-1:0] bp_ras_addr;
    logic                  bp_ras_push;
    logic                  bp_ras_pop;
    logic [ADDR_WIDTH-1:0] ras_bp_addr;

    logic                  bp_decode_valid;
    logic [ADDR_WIDTH-1:0] bp_decode_pc;
    logic [31:0]           bp_decode_inst;
    logic                  bp_decode_jump;
    logic [ADDR_WIDTH-1:0] bp_decode_next_pc;
    logic                  bp_decode_from_ras;
    logic                  decode_bp_ready;

    logic                  flush;
    logic                  bp_csrf_call_add;
    logic                  bp_csrf_ret_add;

    modport master (
        input  fetch_bp_valid, fetch_bp_pc, fetch_bp_inst, ras_bp_addr, decode_bp_ready, flush,
        output bp_fetch_ready, bp_ras_addr, bp_ras_push, bp_ras_pop,
        output bp_decode_valid, bp_decode_pc, bp_decode_inst, bp_decode_jump,
        output bp_decode_next_pc, bp_decode_from_ras, bp_csrf_call_add, bp_csrf_ret_add
    );

    modport slave (
        output fetch_bp_valid, fetch_bp_pc, fetch_bp_inst, ras_bp_addr, decode_bp_ready, flush,
        input  bp_fetch_ready, bp_ras_addr, bp_ras_push, bp_ras_pop,
        input  bp_decode_valid, bp_decode_pc, bp_decode_inst, bp_decode_jump,
        input  bp_decode_next_pc, bp_decode_from_ras, bp_csrf_call_add, bp_csrf_ret_add
    );
endinterface

// File: rtl/ras_bp_ctrl.sv
// RAS front end: decodes JAL/JALR call/return hints, drives RAS push/pop, predicts the next PC
// and registers the instruction plus prediction into a single valid/ready output stage.
module ras_bp_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SHADOW_MAX = 255
) (
    input logic     clk,
    input logic     rst,
    ras_bp_if.master bus
);
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [7:0] ShadowMax = 8'(SHADOW_MAX);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic       is_jal;
    logic       is_jalr;
    logic       link_rd;
    logic       link_rs1;
    logic       ready;
    logic       accept;
    logic       push;
    logic       pop;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] j_imm;
    logic                  pred_jump;
    logic [ADDR_WIDTH-1:0] pred_next_pc;
    logic                  pred_from_ras;

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [31:0]           inst_q;
    logic                  jump_q;
    logic [ADDR_WIDTH-1:0] next_pc_q;
    logic                  from_ras_q;
    logic [7:0]            shadow_q;
    logic [7:0]            shadow_d;

    assign opcode   = bus.fetch_bp_inst[6:0];
    assign rd       = bus.fetch_bp_inst[11:7];
    assign funct3   = bus.fetch_bp_inst[14:12];
    assign rs1      = bus.fetch_bp_inst[19:15];
    assign is_jal   = (opcode == OpJal);
    assign is_jalr  = (opcode == OpJalr) && (funct3 == 3'b000);
    assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

    // Holding rst low also holds ready low, which suppresses every accept-side strobe.
    assign ready  = rst && !bus.flush && (!valid_q || bus.decode_bp_ready);
    assign accept = bus.fetch_bp_valid && ready;

    // Every linking JALR pushes; it also pops when rs1 links and is not the same register.
    assign push = accept && ((is_jal && link_rd) || (is_jalr && link_rd));
    assign pop  = accept && is_jalr && link_rs1 && (!link_rd || (rd != rs1));

    assign pc_plus4 = bus.fetch_bp_pc + ADDR_WIDTH'(4);
    assign j_imm    = {{(ADDR_WIDTH-20){bus.fetch_bp_inst[31]}}, bus.fetch_bp_inst[19:12],
                       bus.fetch_bp_inst[20], bus.fetch_bp_inst[30:21], 1'b0};

    always_comb begin
        pred_jump     = 1'b0;
        pred_next_pc  = pc_plus4;
        pred_from_ras = 1'b0;
        if (is_jal) begin
            pred_jump    = 1'b1;
            pred_next_pc = bus.fetch_bp_pc + j_imm;
        end else if (pop && (shadow_q != 8'd0)) begin
            // An empty shadow means the RAS top is not trustworthy, so fall through instead.
            pred_jump     = 1'b1;
            pred_next_pc  = bus.ras_bp_addr;
            pred_from_ras = 1'b1;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (push && !pop && (shadow_q != ShadowMax)) begin
            shadow_d = shadow_q + 8'd1;
        end else if (pop && !push && (shadow_q != 8'd0)) begin
            shadow_d = shadow_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
            jump_q     <= 1'b0;
            next_pc_q  <= '0;
            from_ras_q <= 1'b0;
            shadow_q   <= 8'd0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q    <= 1'b1;
                pc_q       <= bus.fetch_bp_pc;
                inst_q     <= bus.fetch_bp_inst;
                jump_q     <= pred_jump;
                next_pc_q  <= pred_next_pc;
                from_ras_q <= pred_from_ras;
            end else if (valid_q && bus.decode_bp_ready) begin
                valid_q <= 1'b0;
            end
            shadow_q <= shadow_d;
        end
    end

    assign bus.bp_fetch_ready     = ready;
    assign bus.bp_ras_addr        = pc_plus4;
    assign bus.bp_ras_push        = push;
    assign bus.bp_ras_pop         = pop;
    assign bus.bp_csrf_call_add   = push;
    assign bus.bp_csrf_ret_add    = pop;
    assign bus.bp_decode_valid    = valid_q;
    assign bus.bp_decode_pc       = pc_q;
    assign bus.bp_decode_inst     = inst_q;
    assign bus.bp_decode_jump     = jump_q;
    assign bus.bp_decode_next_pc  = next_pc_q;
    assign bus.bp_decode_from_ras = from_ras_q;
endmodule

// File: tb/tb_ras_bp_ctrl.sv
// Bench for ras_bp_ctrl: directed call/return/backpressure/flush/saturation steps followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_ras_bp_ctrl;
    localparam int KOther = 0;
    localparam int KJal   = 1;
    localparam int KJalr  = 2;
    localparam int KJalrF = 3;  // JALR opcode with nonzero funct3: not a jump

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ras_bp_if #(.ADDR_WIDTH(32)) bus ();

    ras_bp_ctrl #(.ADDR_WIDTH(32), .SHADOW_MAX(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_valid = 0;
    logic [31:0] m_pc = 0;
    logic [31:0] m_inst = 0;
    bit          m_jump = 0;
    logic [31:0] m_next = 0;
    bit          m_from = 0;
    int          m_shadow = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [4:0] pick_reg();
        int sel = $urandom_range(0, 3);
        if (sel == 0) return 5'd0;
        if (sel == 1) return 5'd1;
        if (sel == 2) return 5'd5;
        return 5'($urandom_range(0, 31));
    endfunction

    // One clock: drive at negedge, check strobes mid-cycle, advance model, check stage after edge.
    task automatic cycle(input bit fv, input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [20:0] imm, input logic [31:0] pc, input logic [31:0] ras,
                         input bit dready, input bit fl);
        logic [31:0] inst;
        logic [20:0] imm_e;
        logic [31:0] w;
        bit exp_ready, acc, e_push, e_pop, p_jump, p_from;
        logic [31:0] p_next;
        imm_e = {imm[20:1], 1'b0};
        w = $urandom();
        case (kind)
            KJal:    inst = {imm_e[20], imm_e[10:1], imm_e[11], imm_e[19:12], rd, 7'b1101111};
            KJalr:   inst = {imm_e[11:0], rs1, 3'b000, rd, 7'b1100111};
            KJalrF:  begin
                w[6:0]   = 7'b1100111;
                w[14:12] = 3'($urandom_range(1, 7));
                inst = w;
            end
            default: begin
                w[6:0] = 7'b0110011;
                inst = w;
            end
        endcase

        @(negedge clk);
        bus.fetch_bp_valid  = fv;
        bus.fetch_bp_inst   = inst;
        bus.fetch_bp_pc     = pc;
        bus.ras_bp_addr     = ras;
        bus.decode_bp_ready = dready;
        bus.flush           = fl;
        #1;

        exp_ready = !fl && (!m_valid || dready);
        acc = fv && exp_ready;
        e_push = 0;
        e_pop  = 0;
        if (acc && kind == KJal && is_link(rd)) e_push = 1;
        if (acc && kind == KJalr) begin
            if (!is_link(rd) && is_link(rs1)) e_pop = 1;
            else if (is_link(rd) && !is_link(rs1)) e_push = 1;
            else if (is_link(rd) && is_link(rs1) && rd != rs1) begin
                e_pop = 1;
                e_push = 1;
            end else if (is_link(rd) && rd == rs1) e_push = 1;
        end
        p_jump = 0;
        p_from = 0;
        p_next = pc + 32'd4;
        if (kind == KJal) begin
            p_jump = 1;
            p_next = pc + {{11{imm_e[20]}}, imm_e};
        end else if (e_pop && m_shadow > 0) begin
            p_jump = 1;
            p_next = ras;
            p_from = 1;
        end

        chk("ready", 64'(bus.bp_fetch_ready), 64'(exp_ready));
        chk("push", 64'(bus.bp_ras_push), 64'(e_push));
        chk("pop", 64'(bus.bp_ras_pop), 64'(e_pop));
        chk("ras_addr", 64'(bus.bp_ras_addr), 64'(pc + 32'd4));
        chk("call_add", 64'(bus.bp_csrf_call_add), 64'(e_push));
        chk("ret_add", 64'(bus.bp_csrf_ret_add), 64'(e_pop));

        if (fl) m_valid = 0;
        else if (acc) begin
            m_valid = 1;
            m_pc    = pc;
            m_inst  = inst;
            m_jump  = p_jump;
            m_next  = p_next;
            m_from  = p_from;
        end else if (m_valid && dready) m_valid = 0;
        if (e_push && !e_pop && m_shadow < 255) m_shadow++;
        else if (e_pop && !e_push && m_shadow > 0) m_shadow--;

        @(posedge clk);
        #1;
        chk("dec_valid", 64'(bus.bp_decode_valid), 64'(m_valid));
        chk("dec_pc", 64'(bus.bp_decode_pc), 64'(m_pc));
        chk("dec_inst", 64'(bus.bp_decode_inst), 64'(m_inst));
        chk("dec_jump", 64'(bus.bp_decode_jump), 64'(m_jump));
        chk("dec_next_pc", 64'(bus.bp_decode_next_pc), 64'(m_next));
        chk("dec_from_ras", 64'(bus.bp_decode_from_ras), 64'(m_from));
        chk("shadow", 64'(dut.shadow_q), 64'(m_shadow));
    endtask

    initial begin
        logic [20:0] jimm;
        // Reset held with a call on the fetch port
        jimm = 21'h100;
        bus.fetch_bp_valid  = 1;
        bus.fetch_bp_pc     = 32'h1000;
        bus.fetch_bp_inst   = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'b1101111};
        bus.ras_bp_addr     = 32'h0;
        bus.decode_bp_ready = 1;
        bus.flush           = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.bp_decode_valid), 64'd0);
        chk("rst_push", 64'(bus.bp_ras_push), 64'd0);
        chk("rst_pop", 64'(bus.bp_ras_pop), 64'd0);
        chk("rst_ready", 64'(bus.bp_fetch_ready), 64'd0);
        chk("rst_call", 64'(bus.bp_csrf_call_add), 64'd0);
        chk("rst_next_pc", 64'(bus.bp_decode_next_pc), 64'd0);
        chk("rst_pc", 64'(bus.bp_decode_pc), 64'd0);
        @(negedge clk);
        bus.fetch_bp_valid = 0;
        rst = 1;
        #1;
        chk("rel_ready", 64'(bus.bp_fetch_ready), 64'd1);

        // Call, return with shadow, return with empty shadow
        cycle(1, KJal, 5'd1, 5'd0, 21'h100, 32'h1000, 32'h0, 1, 0);
        cycle(1, KJalr, 5'd0, 5'd1, 21'h0, 32'h2000, 32'h1004, 1, 0);
        cycle(1, KJalr, 5'd0, 5'd1, 21'h0, 32'h2004, 32'h1004, 1, 0);
        // Coroutine swap jalr x1,0(x5) with a nonzero shadow
        cycle(1, KJal, 5'd1, 5'd0, 21'h1FFFF0, 32'h2800, 32'h0, 1, 0);
        cycle(1, KJalr, 5'd1, 5'd5, 21'h0, 32'h3000, 32'h5554, 1, 0);
        // Backpressure: load, hold three cycles, then drain and reload together
        cycle(1, KJal, 5'd5, 5'd0, 21'h40, 32'h4000, 32'h0, 1, 0);
        repeat (3) cycle(1, KJal, 5'd1, 5'd0, 21'h80, 32'h4100, 32'h0, 0, 0);
        cycle(1, KJal, 5'd1, 5'd0, 21'h80, 32'h4100, 32'h0, 1, 0);
        // Flush blocks a call and empties the stage
        cycle(1, KJal, 5'd1, 5'd0, 21'h20, 32'h5000, 32'h0, 1, 1);
        cycle(0, KOther, 5'd0, 5'd0, 21'h0, 32'h5004, 32'h0, 1, 0);
        // Shadow saturation
        for (int i = 0; i < 260; i++)
            cycle(1, KJal, 5'd1, 5'd0, 21'h10, 32'h6000 + 32'(i * 4), 32'h0, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int k = $urandom_range(0, 5);
            int kind = (k <= 1) ? KJalr : (k == 2) ? KJal : (k == 3) ? KJalrF : KOther;
            cycle($urandom_range(0, 4) != 0, kind, pick_reg(), pick_reg(), 21'($urandom()),
                  $urandom(), $urandom(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ras_bp_ctrl.md
Name: ras_bp_ctrl

Overview:
Branch-predictor front end that drives the return address stack (RAS) push/pop interface. It consumes one fetched RV32 instruction per cycle and decodes JAL/JALR using the RISC-V link-register hint rules (link = x1 or x5). It issues push/pop/addr to the RAS and reads the RAS top for return targets. The instruction and its predicted next PC are registered into a single output stage for decode, with valid/ready handshakes on both sides.

Parameters:
ADDR_WIDTH, 32, PC/address width; must equal the RAS address width.
SHADOW_MAX, 255, saturation limit of the outstanding-call shadow counter (8-bit counter).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
fetch_bp_valid  in  1  fetched instruction valid
fetch_bp_pc  in  ADDR_WIDTH  instruction PC
fetch_bp_inst  in  32  instruction word
bp_fetch_ready  out  1  block can accept this cycle
bp_ras_addr  out  ADDR_WIDTH  push address (pc+4)
bp_ras_push  out  1  push strobe to RAS
bp_ras_pop  out  1  pop strobe to RAS
ras_bp_addr  in  ADDR_WIDTH  current RAS top
bp_decode_valid  out  1  output stage valid
bp_decode_pc  out  ADDR_WIDTH  registered PC
bp_decode_inst  out  32  registered instruction
bp_decode_jump  out  1  predicted redirect
bp_decode_next_pc  out  ADDR_WIDTH  predicted next PC
bp_decode_from_ras  out  1  next_pc came from RAS
decode_bp_ready  in  1  downstream accepts
flush  in  1  pipeline flush
bp_csrf_call_add  out  1  call-push event pulse
bp_csrf_ret_add  out  1  return-pop event pulse

Behaviour:
- Reset (rst=0, async): bp_decode_valid=0; all bp_decode_* data=0; shadow counter=0. While rst=0: bp_ras_push=0, bp_ras_pop=0, bp_fetch_ready=0, csr pulses=0.
- bp_fetch_ready = !flush && (!bp_decode_valid || decode_bp_ready). Accept = fetch_bp_valid && bp_fetch_ready.
- Decode (combinational, only on accept): JAL opcode 7'b1101111; JALR opcode 7'b1100111 with funct3=0. link(r) = (r==1 || r==5).
- Actions:
  - JAL with link(rd): push.
  - JALR with !link(rd) && link(rs1): pop.
  - JALR with link(rd) && !link(rs1): push.
  - JALR with link(rd) && link(rs1) && rd!=rs1: pop and push together.
  - JALR with link(rd) && rd==rs1: push.
  - All other instructions: none.
- bp_ras_push/bp_ras_pop are combinational and asserted only in the accept cycle. bp_ras_addr = fetch_bp_pc+4 (mod 2^ADDR_WIDTH), driven always.
- Prediction, sampled in the accept cycle:
  - JAL: jump=1, next_pc = pc + sign-extended J-immediate.
  - Pop-class JALR with shadow>0: jump=1, next_pc = ras_bp_addr (value before the pop commits), from_ras=1.
  - Pop-class JALR with shadow==0: jump=0, next_pc=pc+4, from_ras=0; the pop is still issued.
  - Other JALR and non-jumps: jump=0, next_pc=pc+4.
- Output stage:
  - On accept, load all bp_decode_* and set valid=1 at the next edge (1-cycle latency).
  - If valid && decode_bp_ready && !accept, clear valid at the next edge.
  - If valid && !decode_bp_ready, hold all outputs stable.
- Shadow counter:
  - push-only: +1, saturating at SHADOW_MAX.
  - pop-only: -1, saturating at 0.
  - pop+push together: unchanged.
- Flush: clears valid at the next edge (overrides a load) and blocks accept that cycle (no push/pop). It does not alter the shadow counter.
- CSR pulses, combinational in the accept cycle: bp_csrf_call_add = push; bp_csrf_ret_add = pop.
- rst deasserted mid-stream: the first accept is possible in the cycle after release.

Test Plan:
- Reset: hold rst=0 with fetch_bp_valid=1 -> valid=0, push=pop=0, ready=0; release -> ready=1.
- JAL x1,+0x100 at pc 0x1000 -> push=1, addr=0x1004, call_add=1; next cycle valid=1, jump=1, next_pc=0x1100, shadow=1.
- jalr x0,0(x1) at pc 0x2000, shadow=1, ras_bp_addr=0x1004 -> pop=1, ret_add=1; next cycle next_pc=0x1004, from_ras=1, shadow=0. Repeat with shadow=0 -> pop=1, jump=0, next_pc=0x2008.
- jalr x1,0(x5) at pc 0x3000 -> push=pop=1 in same cycle, addr=0x3004, shadow unchanged, next_pc=ras_bp_addr.
- Backpressure: valid=1, decode_bp_ready=0, fetch_bp_valid=1 -> ready=0, no push, outputs held 3 cycles; raise ready -> drain and reload same cycle.
- Flush with fetch JAL x1 present -> no push, valid=0 next cycle; 256 consecutive JAL x1 calls -> shadow saturates at 255.
